// File: rtl/difftest_load_event_gen_pkg.sv
// Shared definitions for the difftest load-event generator.
// - load_event_t : one buffered memory event (address, op encoding, kind flags)
// - DT_INDEX_W   : width of the running event sequence number
package difftest_load_event_gen_pkg;

  localparam int DT_INDEX_W = 8;
  localparam int PADDR_W    = 64;
  localparam int OPTYPE_W   = 8;

  typedef struct packed {
    logic [PADDR_W-1:0]  paddr;
    logic [OPTYPE_W-1:0] optype;
    logic                is_atomic;
    logic                is_load;
  } load_event_t;

endpackage

// File: rtl/difftest_event_fifo.sv
// Circular buffer of DEPTH entries of a generic entry type.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   push, push_data   : write push_data at tail (ignored while flush is high)
//   pop, pop_data     : pop_data always shows the head entry; pop advances head
//   flush             : discard everything; head snaps to tail
//   count, full       : occupancy at cycle start and (count == DEPTH)
module difftest_event_fifo
  import difftest_load_event_gen_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = load_event_t
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   pop_data,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_nxt;
  logic [PTR_W-1:0] tail_nxt;
  logic             push_en;

  // A flush wins over a simultaneous push so head/tail stay consistent.
  assign push_en  = push & ~flush;
  assign head_nxt = (head == LAST_PTR) ? '0 : head + 1'b1;
  assign tail_nxt = (tail == LAST_PTR) ? '0 : tail + 1'b1;
  assign pop_data = mem[head];
  assign full     = (count == DEPTH_C);

  always_ff @(posedge clock) begin
    if (push_en) begin
      mem[tail] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push_en) tail <= tail_nxt;
      if (pop)     head <= head_nxt;
      unique case ({push_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/difftest_load_event_gen.sv
// Buffers completed load-pipeline memory events and emits them, in order,
// to the difftest load-event sink as they retire.
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   ld_valid/ld_ready            : event offer / buffer has room
//   ld_paddr/ld_optype/...       : fields of the offered event
//   commit_valid                 : oldest buffered event retires this cycle
//   flush                        : discard all uncommitted events
//   dt_enable/dt_valid           : one-cycle strobe per emitted event
//   dt_paddr/dt_optype/...       : emitted event fields (held when idle)
//   dt_coreid                    : constant COREID
//   dt_index                     : sequence number of the emitted event
//   commit_underflow             : sticky, commit seen with an empty buffer
module difftest_load_event_gen
  import difftest_load_event_gen_pkg::*;
#(
  parameter int         DEPTH  = 4,
  parameter logic [7:0] COREID = 8'd0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [PADDR_W-1:0]    ld_paddr,
  input  logic [OPTYPE_W-1:0]   ld_optype,
  input  logic                  ld_is_atomic,
  input  logic                  ld_is_load,
  input  logic                  commit_valid,
  input  logic                  flush,
  output logic                  dt_enable,
  output logic                  dt_valid,
  output logic [PADDR_W-1:0]    dt_paddr,
  output logic [OPTYPE_W-1:0]   dt_optype,
  output logic                  dt_is_atomic,
  output logic                  dt_is_load,
  output logic [7:0]            dt_coreid,
  output logic [DT_INDEX_W-1:0] dt_index,
  output logic                  commit_underflow
);

  logic [$clog2(DEPTH):0] count;
  logic                   full;
  load_event_t            in_evt_p0;
  load_event_t            head_evt_p0;
  logic                   push_p0;
  logic                   pop_p0;
  logic                   underflow_p0;

  load_event_t            evt_p1;
  logic                   vld_p1;
  logic [DT_INDEX_W-1:0]  idx_p1;
  logic [DT_INDEX_W-1:0]  seq_q;
  logic                   underflow_q;

  // Stage p0: accept/retire decisions use occupancy at cycle start only,
  // so a same-cycle push never satisfies a commit.
  assign ld_ready     = ~full;
  assign push_p0      = ld_valid & ld_ready & ~flush;
  assign pop_p0       = commit_valid & (count != '0);
  assign underflow_p0 = commit_valid & (count == '0);

  always_comb begin
    in_evt_p0           = '0;
    in_evt_p0.paddr     = ld_paddr;
    in_evt_p0.optype    = ld_optype;
    in_evt_p0.is_atomic = ld_is_atomic;
    in_evt_p0.is_load   = ld_is_load;
  end

  difftest_event_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (load_event_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_p0),
    .push_data (in_evt_p0),
    .pop       (pop_p0),
    .pop_data  (head_evt_p0),
    .flush     (flush),
    .count     (count),
    .full      (full)
  );

  // Stage p1: registered emit. Fields are only loaded on a pop so they
  // hold the last emitted event while idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      evt_p1      <= '0;
      idx_p1      <= '0;
      seq_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      vld_p1 <= pop_p0;
      if (pop_p0) begin
        evt_p1 <= head_evt_p0;
        idx_p1 <= seq_q;
        seq_q  <= seq_q + 1'b1;
      end
      if (underflow_p0) underflow_q <= 1'b1;
    end
  end

  assign dt_enable        = vld_p1;
  assign dt_valid         = vld_p1;
  assign dt_paddr         = evt_p1.paddr;
  assign dt_optype        = evt_p1.optype;
  assign dt_is_atomic     = evt_p1.is_atomic;
  assign dt_is_load       = evt_p1.is_load;
  assign dt_coreid        = COREID;
  assign dt_index         = idx_p1;
  assign commit_underflow = underflow_q;

endmodule

// File: tb/tb_difftest_load_event_gen.sv
module tb_difftest_load_event_gen;
  import difftest_load_event_gen_pkg::*;

  localparam int         DEPTH  = 4;
  localparam logic [7:0] COREID = 8'h2C;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic        ld_ready;
  logic [63:0] ld_paddr;
  logic [7:0]  ld_optype;
  logic        ld_is_atomic;
  logic        ld_is_load;
  logic        commit_valid;
  logic        flush;
  logic        dt_enable;
  logic        dt_valid;
  logic [63:0] dt_paddr;
  logic [7:0]  dt_optype;
  logic        dt_is_atomic;
  logic        dt_is_load;
  logic [7:0]  dt_coreid;
  logic [7:0]  dt_index;
  logic        commit_underflow;

  difftest_load_event_gen #(.DEPTH(DEPTH), .COREID(COREID)) dut (
    .clock            (clock),
    .reset            (reset),
    .ld_valid         (ld_valid),
    .ld_ready         (ld_ready),
    .ld_paddr         (ld_paddr),
    .ld_optype        (ld_optype),
    .ld_is_atomic     (ld_is_atomic),
    .ld_is_load       (ld_is_load),
    .commit_valid     (commit_valid),
    .flush            (flush),
    .dt_enable        (dt_enable),
    .dt_valid         (dt_valid),
    .dt_paddr         (dt_paddr),
    .dt_optype        (dt_optype),
    .dt_is_atomic     (dt_is_atomic),
    .dt_is_load       (dt_is_load),
    .dt_coreid        (dt_coreid),
    .dt_index         (dt_index),
    .commit_underflow (commit_underflow)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a queue of pending events plus the last emitted event.
  load_event_t mq[$];
  load_event_t m_evt;
  logic        m_vld;
  logic [7:0]  m_idx;
  int          m_emitted;
  logic        m_uf;
  int          idx_seen[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict, clock, compare every output.
  task automatic cyc(input logic lv, input logic [63:0] pa, input logic [7:0] op,
                     input logic at, input logic ld, input logic cv,
                     input logic fl, input logic rs);
    int          sz;
    load_event_t e;
    reset = rs; ld_valid = lv; ld_paddr = pa; ld_optype = op;
    ld_is_atomic = at; ld_is_load = ld; commit_valid = cv; flush = fl;
    #1;
    chk("ld_ready", ld_ready, mq.size() < DEPTH);
    if (rs) begin
      mq.delete();
      m_vld = 0; m_evt = '0; m_idx = 0; m_emitted = 0; m_uf = 0;
    end else begin
      sz    = mq.size();
      m_vld = 0;
      if (cv && sz > 0) begin
        m_evt = mq.pop_front();
        m_vld = 1;
        m_idx = 8'(m_emitted % 256);
        m_emitted++;
        idx_seen.push_back(int'(m_idx));
      end
      if (cv && sz == 0) m_uf = 1;
      if (fl) mq.delete();
      else if (lv && sz < DEPTH) begin
        e.paddr = pa; e.optype = op; e.is_atomic = at; e.is_load = ld;
        mq.push_back(e);
      end
    end
    @(posedge clock);
    #1;
    chk("dt_valid",     dt_valid,         m_vld);
    chk("dt_enable",    dt_enable,        m_vld);
    chk("dt_paddr",     dt_paddr,         m_evt.paddr);
    chk("dt_optype",    dt_optype,        m_evt.optype);
    chk("dt_is_atomic", dt_is_atomic,     m_evt.is_atomic);
    chk("dt_is_load",   dt_is_load,       m_evt.is_load);
    chk("dt_index",     dt_index,         m_idx);
    chk("dt_coreid",    dt_coreid,        COREID);
    chk("underflow",    commit_underflow, m_uf);
  endtask

  task automatic idle(input logic cv = 0);
    cyc(0, 64'h0, 8'h0, 0, 0, cv, 0, 0);
  endtask

  task automatic rpush(input logic cv, input logic fl);
    cyc(1, {$urandom, $urandom}, 8'($urandom), 1'($urandom), 1'($urandom), cv, fl, 0);
  endtask

  task automatic do_reset();
    cyc(0, 64'h0, 8'h0, 0, 0, 0, 0, 1);
    cyc(0, 64'h0, 8'h0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    reset = 1; ld_valid = 0; ld_paddr = 0; ld_optype = 0;
    ld_is_atomic = 0; ld_is_load = 0; commit_valid = 0; flush = 0;
    mq.delete(); m_evt = '0; m_vld = 0; m_idx = 0; m_emitted = 0; m_uf = 0;
    @(posedge clock); #1;
    do_reset();
    chk("rst_ready", ld_ready, 1'b1);

    // First event: single push then commit.
    cyc(1, 64'h8000_1000, 8'h03, 0, 1, 0, 0, 0);
    cyc(0, 64'h0, 8'h0, 0, 0, 1, 0, 0);
    chk("first_valid", dt_valid, 1'b1);
    chk("first_paddr", dt_paddr, 64'h8000_1000);
    chk("first_index", dt_index, 8'd0);
    idle();
    chk("first_one_cycle", dt_valid, 1'b0);

    // Fill to full, offer a fifth, then drain in order.
    for (int i = 0; i < DEPTH; i++) cyc(1, 64'h1000 + 64'(i), 8'(i), 0, 1, 0, 0, 0);
    chk("full_ready", ld_ready, 1'b0);
    cyc(1, 64'hDEAD, 8'hEE, 1, 0, 0, 0, 0);
    cyc(0, 64'h0, 8'h0, 0, 0, 1, 0, 0);
    chk("after_commit_ready", ld_ready, 1'b1);
    chk("fifo_order0", dt_paddr, 64'h1000);
    for (int i = 1; i < DEPTH; i++) begin
      idle(1);
      chk("fifo_order", dt_paddr, 64'h1000 + 64'(i));
    end
    idle();

    // Long streaming run: index wrap and many pointer wraps.
    do_reset();
    idx_seen.delete();
    rpush(0, 0);
    for (int i = 0; i < 257; i++) rpush(1, 0);
    idle(1);
    chk("wrap_count", idx_seen.size(), 258);
    for (int i = 0; i < idx_seen.size(); i++)
      if (i == 255 || i == 256 || i == 0) chk("wrap_idx", idx_seen[i], i % 256);
    chk("wrap_last_index", dt_index, 8'd1);

    // Flush together with commit while three entries are buffered.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 64'h2000 + 64'(i), 8'h10, 0, 1, 0, 0, 0);
    cyc(1, 64'hBAD, 8'h0, 0, 1, 1, 1, 0);
    chk("flush_emit_paddr", dt_paddr, 64'h2000);
    chk("flush_ready", ld_ready, 1'b1);
    idle(1);
    chk("flush_no_more", dt_valid, 1'b0);

    // Commit while empty with a simultaneous push.
    do_reset();
    cyc(1, 64'h3000, 8'h22, 1, 0, 1, 0, 0);
    chk("uf_set", commit_underflow, 1'b1);
    idle(1);
    chk("uf_push_kept", dt_paddr, 64'h3000);
    for (int i = 0; i < 3; i++) idle();
    chk("uf_held", commit_underflow, 1'b1);

    // Reset right after a commit.
    do_reset();
    cyc(1, 64'h4000, 8'h33, 0, 1, 0, 0, 0);
    cyc(1, 64'h4001, 8'h34, 0, 1, 1, 0, 0);
    cyc(0, 64'h0, 8'h0, 0, 0, 1, 0, 1);
    chk("rst_mid_valid", dt_valid, 1'b0);
    chk("rst_mid_paddr", dt_paddr, 64'h0);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 8'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 127) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/difftest_load_event_gen.md
DIFFTEST_LOAD_EVENT_GEN -- requirements
Module: difftest_load_event_gen

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of buffered load events; power of two, 2..16.
REQ-002 Parameter COREID, default 0, meaning 8-bit hart id driven on dt_coreid.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ld_valid  input  1  load pipeline offers a completed memory event.
REQ-006 ld_ready  output  1  buffer accepts the event this cycle.
REQ-007 ld_paddr  input  64  physical address of the access.
REQ-008 ld_optype  input  8  load op encoding, passed through unchanged.
REQ-009 ld_is_atomic  input  1  event is an AMO or LR/SC.
REQ-010 ld_is_load  input  1  event is a plain load.
REQ-011 commit_valid  input  1  oldest buffered event retired this cycle.
REQ-012 flush  input  1  pipeline flush; uncommitted events are discarded.
REQ-013 dt_enable, dt_valid  output  1 each  event strobe to the difftest load-event sink.
REQ-014 dt_paddr/dt_optype/dt_is_atomic/dt_is_load  output  64/8/1/1  fields of the emitted event.
REQ-015 dt_coreid  output  8  constant COREID.
REQ-016 dt_index  output  8  running event sequence number.
REQ-017 commit_underflow  output  1  sticky error flag.

Function
REQ-018 Storage is a circular FIFO of DEPTH entries with head/tail pointers and a count of width log2(DEPTH)+1.
REQ-019 ld_ready SHALL equal (count < DEPTH) and SHALL be independent of commit_valid and flush in the same cycle.
REQ-020 A push SHALL occur when ld_valid && ld_ready && !flush; it writes the entry at tail, and tail wraps DEPTH-1 -> 0.
REQ-021 A pop SHALL occur when commit_valid && count_at_cycle_start > 0; it reads the entry at head, and head wraps DEPTH-1 -> 0.
REQ-022 A push arriving in a cycle does not satisfy a commit in that same cycle; a commit SHALL only consume entries present at cycle start.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged.
REQ-024 Each pop SHALL produce exactly one output event one cycle later: dt_enable=dt_valid=1 for one cycle, and the dt_* fields hold the popped entry.
REQ-025 When no event is emitted, dt_enable=dt_valid=0 and the dt_* fields SHALL hold their last values.
REQ-026 dt_index SHALL equal the number of events emitted since reset, modulo 256: the first event carries 0, and 255 wraps to 0.
REQ-027 commit_valid with count_at_cycle_start == 0 SHALL not pop or emit, and SHALL set commit_underflow, which stays 1 until reset.
REQ-028 On flush, count SHALL become 0 and head SHALL equal tail next cycle; dt_index SHALL be unaffected.
REQ-029 Flush together with commit: the commit's pop and emit SHALL complete, and all remaining entries are discarded.
REQ-030 Flush together with ld_valid: the offered event SHALL be dropped (no push).

Reset
REQ-031 During reset: head=tail=count=0, dt_enable=dt_valid=0, dt_paddr=0, dt_optype=0, dt_is_atomic=0, dt_is_load=0, dt_index=0, commit_underflow=0; ld_ready=1 after reset.
REQ-032 Reset asserted mid-operation SHALL discard all entries and suppress any pending emit in the following cycle.
REQ-033 FIFO data array contents need not be reset.

Structure
REQ-034 The load-event entry struct (paddr, optype, is_atomic, is_load) and the index width constant SHALL live in the shared difftest package.
REQ-035 The circular buffer SHALL be one sub-module, difftest_event_fifo, parameterised on DEPTH and entry type; the top adds commit/emit/index logic.

Verification
REQ-036 After reset, push paddr 0x8000_1000, optype 0x03, is_load=1, then commit -> dt_valid exactly 1 cycle after the commit, paddr 0x8000_1000, dt_index=0, coreid=COREID.
REQ-037 Fill 4 entries with no commits -> ld_ready=0 and a 5th ld_valid is not accepted; one commit -> ld_ready=1 next cycle, and events emit in FIFO order.
REQ-038 Emit 257 events -> dt_index values run 0..255, 0; wrap of head/tail is exercised at least 60 times.
REQ-039 3 entries buffered, flush+commit in the same cycle -> exactly one event emitted (the oldest), then count=0 and ld_ready=1.
REQ-040 commit_valid while empty -> no dt_valid, commit_underflow=1 and held until reset; a simultaneous push is still stored.
REQ-041 Assert reset one cycle after a commit -> no dt_valid in the following cycle, and all outputs are at their REQ-031 values.
